// File: rtl/encoder_job_sched.sv
// -----------------------------------------------------------------------------
// encoder_job_sched
//
// Accepts encode jobs from two requesters through a round-robin arbiter. Jobs
// wait in a small FIFO. A four-state controller then runs them one at a time:
// it issues a start pulse, counts the encoder's SPM write beats, and reports
// completion. A job that runs past its cycle budget is reported as an error.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   reqN_valid / reqN_ready          job offer handshake (N = 0, 1)
//   reqN_base_addr, reqN_poly_id     job payload
//   ctrl_start                       one-cycle start pulse to the encoder
//   encode2spm_base_addr, poly_id_o  payload of the active (or last) job
//   encode_wr_en                     encoder SPM write strobe, one beat/cycle
//   done_valid, done_id, done_err    one-cycle completion report
//   busy                             controller active or jobs queued
// -----------------------------------------------------------------------------
module encoder_job_sched #(
  parameter int SPM_ADDR_WIDTH = 14,
  parameter int ID_WIDTH       = 11,
  parameter int FIFO_DEPTH     = 4,
  parameter int WR_PER_JOB     = 4,
  parameter int TIMEOUT        = 65535
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [SPM_ADDR_WIDTH-1:0] req0_base_addr,
  input  logic [ID_WIDTH-1:0]       req0_poly_id,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [SPM_ADDR_WIDTH-1:0] req1_base_addr,
  input  logic [ID_WIDTH-1:0]       req1_poly_id,
  output logic                      ctrl_start,
  output logic [SPM_ADDR_WIDTH-1:0] encode2spm_base_addr,
  output logic [ID_WIDTH-1:0]       poly_id_o,
  input  logic                      encode_wr_en,
  output logic                      done_valid,
  output logic [ID_WIDTH-1:0]       done_id,
  output logic                      done_err,
  output logic                      busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(WR_PER_JOB + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [SPM_ADDR_WIDTH-1:0] fifo_base [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]       fifo_id   [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]          count_q;
  logic                      prio_q;     // 0: req0 wins a tie, 1: req1 wins
  logic [SPM_ADDR_WIDTH-1:0] base_q;
  logic [ID_WIDTH-1:0]       id_q;
  logic [BEAT_W-1:0]         beat_q;
  logic [TMO_W-1:0]          tmo_q;
  logic                      err_q;

  logic                      can_accept, grant0, grant1, push, pop;
  logic                      beat_hit, tmo_hit;
  logic [SPM_ADDR_WIDTH-1:0] push_base;
  logic [ID_WIDTH-1:0]       push_id;

  // ---------------------------------------------------------------------------
  // Arbiter: a lone valid requester always wins; a tie goes to the pointer.
  // ---------------------------------------------------------------------------
  assign can_accept = count_q < CNT_W'(FIFO_DEPTH);
  assign grant0     = can_accept & req0_valid & (~req1_valid | ~prio_q);
  assign grant1     = can_accept & req1_valid & (~req0_valid |  prio_q);
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign push       = grant0 | grant1;
  assign push_base  = grant1 ? req1_base_addr : req0_base_addr;
  assign push_id    = grant1 ? req1_poly_id   : req0_poly_id;

  // The pop decision uses the registered count, so a job pushed this cycle is
  // never visible to the controller until the next one.
  assign pop = (state_q == S_IDLE) && (count_q != '0);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      prio_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // The pointer hands priority to whoever was not just served.
      if (grant0)      prio_q <= 1'b1;
      else if (grant1) prio_q <= 1'b0;
    end
  end

  // NOTE: the queue storage has no reset; an entry is only read after it has
  // been written, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_base[wr_ptr_q] <= push_base;
      fifo_id[wr_ptr_q]   <= push_id;
    end
  end

  // ---------------------------------------------------------------------------
  // Job controller
  // ---------------------------------------------------------------------------
  assign beat_hit = encode_wr_en && (beat_q == BEAT_W'(WR_PER_JOB - 1));
  assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT - 1));

  // NOTE: next-state is assigned a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_START;
      S_START: state_d = S_BUSY;
      S_BUSY:  if (beat_hit || tmo_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      id_q    <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            base_q <= fifo_base[rd_ptr_q];
            id_q   <= fifo_id[rd_ptr_q];
          end
        end
        S_START: begin
          beat_q <= '0;
          tmo_q  <= '0;
          err_q  <= 1'b0;
        end
        S_BUSY: begin
          // Both counters stop at most one past their limit because the
          // controller leaves BUSY on the cycle that reaches it.
          if (encode_wr_en) beat_q <= beat_q + 1'b1;
          tmo_q <= tmo_q + 1'b1;
          // A final beat on the last allowed cycle still counts as success.
          if (tmo_hit && !beat_hit) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ctrl_start           = (state_q == S_START);
  assign done_valid           = (state_q == S_DONE);
  assign done_id              = done_valid ? id_q : '0;
  assign done_err             = done_valid & err_q;
  assign encode2spm_base_addr = base_q;
  assign poly_id_o            = id_q;
  assign busy                 = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_encoder_job_sched.sv
// -----------------------------------------------------------------------------
// tb_encoder_job_sched
//
// Drives directed and random traffic into encoder_job_sched. A job-level model
// (a queue of pending jobs plus the start/finish cycle of the active job)
// predicts every output on every cycle. Directed sequences additionally pin
// the model with hand-computed cycle offsets and completion orders.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_encoder_job_sched;

  localparam int AW    = 14;
  localparam int IW    = 11;
  localparam int DEPTH = 4;
  localparam int WR    = 4;
  localparam int TMO   = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_base_addr = '0, req1_base_addr = '0;
  logic [IW-1:0] req0_poly_id = '0, req1_poly_id = '0;
  logic          ctrl_start;
  logic [AW-1:0] encode2spm_base_addr;
  logic [IW-1:0] poly_id_o;
  logic          encode_wr_en = 1'b0;
  logic          done_valid;
  logic [IW-1:0] done_id;
  logic          done_err;
  logic          busy;

  always #5 clk = ~clk;

  encoder_job_sched #(
    .SPM_ADDR_WIDTH(AW), .ID_WIDTH(IW), .FIFO_DEPTH(DEPTH),
    .WR_PER_JOB(WR), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_base_addr(req0_base_addr), .req0_poly_id(req0_poly_id),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_base_addr(req1_base_addr), .req1_poly_id(req1_poly_id),
    .ctrl_start(ctrl_start), .encode2spm_base_addr(encode2spm_base_addr),
    .poly_id_o(poly_id_o), .encode_wr_en(encode_wr_en),
    .done_valid(done_valid), .done_id(done_id), .done_err(done_err),
    .busy(busy)
  );

  typedef struct packed {
    logic [AW-1:0] base;
    logic [IW-1:0] id;
  } job_t;

  // Job-level model
  job_t          mq[$];
  bit            m_act, m_err, m_ptr;
  int            m_start, m_done, m_beats;
  logic [AW-1:0] m_base;
  logic [IW-1:0] m_id;
  bit            g0, g1;

  int cnum;
  int tests, fails;

  logic          snap_r0, snap_r1, snap_cs, snap_dv, snap_derr, snap_busy;
  logic [AW-1:0] snap_base;
  logic [IW-1:0] snap_id, snap_did;

  int ev_start[$], ev_done_k[$], ev_done_id[$], ev_done_err[$];
  bit beat_at[64];
  int exp_order[5] = '{10, 20, 11, 21, 12};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cnum);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_act = 0; m_err = 0; m_ptr = 0;
    m_start = -1; m_done = -1; m_beats = 0;
    m_base = '0; m_id = '0;
    g0 = 0; g1 = 0;
  endfunction

  // One clock cycle: sample at the falling edge, compare against the model,
  // advance the model, then return just after the next rising edge.
  task automatic cyc();
    bit   can, e_cs, e_dv, e_busy;
    job_t j;
    @(negedge clk);
    cnum++;
    snap_r0 = req0_ready;  snap_r1 = req1_ready;
    snap_cs = ctrl_start;  snap_dv = done_valid;
    snap_did = done_id;    snap_derr = done_err;
    snap_base = encode2spm_base_addr; snap_id = poly_id_o;
    snap_busy = busy;

    can    = mq.size() < DEPTH;
    g0     = can && req0_valid && (!req1_valid || !m_ptr);
    g1     = can && req1_valid && (!req0_valid ||  m_ptr);
    e_cs   = m_act && (cnum == m_start);
    e_dv   = m_act && (cnum == m_done);
    e_busy = m_act || (mq.size() != 0);

    check("req0_ready", 32'(snap_r0), 32'(g0));
    check("req1_ready", 32'(snap_r1), 32'(g1));
    check("ctrl_start", 32'(snap_cs), 32'(e_cs));
    check("done_valid", 32'(snap_dv), 32'(e_dv));
    if (e_dv) begin
      check("done_id", 32'(snap_did), 32'(m_id));
      check("done_err", 32'(snap_derr), 32'(m_err));
    end
    check("base_addr", 32'(snap_base), 32'(m_base));
    check("poly_id_o", 32'(snap_id), 32'(m_id));
    check("busy", 32'(snap_busy), 32'(e_busy));

    if (m_act) begin
      if (cnum == m_done) m_act = 0;
      else if (cnum > m_start) begin
        if (encode_wr_en) m_beats++;
        if (m_beats == WR) begin
          m_done = cnum + 1; m_err = 0;
        end else if (cnum - m_start == TMO) begin
          m_done = cnum + 1; m_err = 1;
        end
      end
    end else if (mq.size() != 0) begin
      j = mq.pop_front();
      m_act = 1; m_start = cnum + 1; m_done = -1; m_beats = 0; m_err = 0;
      m_base = j.base; m_id = j.id;
    end
    if (g0) begin
      mq.push_back(job_t'{base: req0_base_addr, id: req0_poly_id}); m_ptr = 1;
    end else if (g1) begin
      mq.push_back(job_t'{base: req1_base_addr, id: req1_poly_id}); m_ptr = 0;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 0; req1_valid = 0; encode_wr_en = 0;
    rst_n = 1'b0;
    #2;
    check("rst ctrl_start", 32'(ctrl_start), 32'd0);
    check("rst done_valid", 32'(done_valid), 32'd0);
    check("rst done_err", 32'(done_err), 32'd0);
    check("rst done_id", 32'(done_id), 32'd0);
    check("rst base_addr", 32'(encode2spm_base_addr), 32'd0);
    check("rst poly_id_o", 32'(poly_id_o), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push0(input int id);
    req0_valid = 1; req1_valid = 0;
    req0_base_addr = AW'(id * 3); req0_poly_id = IW'(id);
    cyc();
    check($sformatf("push id %0d accepted", id), 32'(snap_r0), 32'd1);
    req0_valid = 0;
  endtask

  // Runs ncyc cycles; beats are driven at offsets (in beat_at) counted from
  // the first ctrl_start seen. Records start and done events at those offsets.
  task automatic watch(input int ncyc);
    int k, tk;
    k = -1;
    ev_start.delete(); ev_done_k.delete(); ev_done_id.delete(); ev_done_err.delete();
    for (int i = 0; i < ncyc; i++) begin
      encode_wr_en = (k >= 0 && k < 64) ? beat_at[k] : 1'b0;
      cyc();
      tk = (k < 0 && snap_cs) ? 0 : k;
      if (snap_cs) ev_start.push_back(tk);
      if (snap_dv) begin
        ev_done_k.push_back(tk);
        ev_done_id.push_back(int'(snap_did));
        ev_done_err.push_back(int'(snap_derr));
      end
      k = (tk >= 0) ? tk + 1 : -1;
    end
    encode_wr_en = 0;
  endtask

  task automatic test_contention();
    int id0, id1;
    int got[$];
    bit er0[8] = '{1, 0, 1, 0, 1, 0, 0, 0};
    bit er1[8] = '{0, 1, 0, 1, 0, 0, 0, 0};
    id0 = 10; id1 = 20;
    for (int i = 0; i < 8; i++) begin
      req0_valid = 1; req1_valid = 1;
      req0_poly_id = IW'(id0); req0_base_addr = AW'(id0 * 16);
      req1_poly_id = IW'(id1); req1_base_addr = AW'(id1 * 16);
      cyc();
      check($sformatf("contention r0 c%0d", i), 32'(snap_r0), 32'(er0[i]));
      check($sformatf("contention r1 c%0d", i), 32'(snap_r1), 32'(er1[i]));
      if (snap_r0) id0++;
      if (snap_r1) id1++;
    end
    req0_valid = 0; req1_valid = 0;
    encode_wr_en = 1;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (snap_dv) got.push_back(int'(snap_did));
    end
    encode_wr_en = 0;
    check("contention done count", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("contention done order %0d", i), 32'(qget(got, i)), 32'(exp_order[i]));
  endtask

  task automatic test_single();
    req0_valid = 1; req1_valid = 0;
    req0_base_addr = AW'(16'h0100); req0_poly_id = IW'(5);
    cyc();
    check("single accept", 32'(snap_r0), 32'd1);
    req0_valid = 0;
    cyc();
    check("single no early start", 32'(snap_cs), 32'd0);
    cyc();
    check("single ctrl_start", 32'(snap_cs), 32'd1);
    check("single base", 32'(snap_base), 32'h100);
    check("single id", 32'(snap_id), 32'd5);
    encode_wr_en = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check($sformatf("single no done beat %0d", i), 32'(snap_dv), 32'd0);
    end
    encode_wr_en = 0;
    cyc();
    check("single done_valid", 32'(snap_dv), 32'd1);
    check("single done_id", 32'(snap_did), 32'd5);
    check("single done_err", 32'(snap_derr), 32'd0);
    cyc();
    check("single idle busy", 32'(snap_busy), 32'd0);
  endtask

  task automatic test_timeout();
    push0(30);
    push0(31);
    beat_at = '{default: 1'b0};
    beat_at[2] = 1; beat_at[3] = 1;                       // job 30: only 2 beats
    beat_at[30] = 1; beat_at[32] = 1; beat_at[34] = 1; beat_at[35] = 1; // job 31
    watch(45);
    check("tmo start count", 32'(ev_start.size()), 32'd2);
    check("tmo second start k", 32'(qget(ev_start, 1)), 32'd19);
    check("tmo done count", 32'(ev_done_k.size()), 32'd2);
    check("tmo done1 k", 32'(qget(ev_done_k, 0)), 32'd17);
    check("tmo done1 id", 32'(qget(ev_done_id, 0)), 32'd30);
    check("tmo done1 err", 32'(qget(ev_done_err, 0)), 32'd1);
    check("edge done2 k", 32'(qget(ev_done_k, 1)), 32'd36);
    check("edge done2 id", 32'(qget(ev_done_id, 1)), 32'd31);
    check("edge done2 err", 32'(qget(ev_done_err, 1)), 32'd0);

    // Strobes while idle must not count toward the next job.
    encode_wr_en = 1;
    repeat (5) cyc();
    encode_wr_en = 0;
    push0(33);
    beat_at = '{default: 1'b0};
    beat_at[1] = 1; beat_at[2] = 1; beat_at[3] = 1; beat_at[5] = 1;
    watch(12);
    check("idle-strobe done count", 32'(ev_done_k.size()), 32'd1);
    check("idle-strobe done k", 32'(qget(ev_done_k, 0)), 32'd6);
    check("idle-strobe done id", 32'(qget(ev_done_id, 0)), 32'd33);
    check("idle-strobe done err", 32'(qget(ev_done_err, 0)), 32'd0);
  endtask

  task automatic test_reset_mid_job();
    for (int i = 40; i < 44; i++) push0(i);
    encode_wr_en = 1;
    repeat (2) cyc();
    encode_wr_en = 0;
    check("pre-reset busy", 32'(snap_busy), 32'd1);
    do_reset();
    cyc();
    check("post-reset busy", 32'(snap_busy), 32'd0);
    push0(50);
    beat_at = '{default: 1'b0};
    for (int i = 1; i <= 4; i++) beat_at[i] = 1;
    watch(20);
    check("post-reset done count", 32'(ev_done_k.size()), 32'd1);
    check("post-reset done k", 32'(qget(ev_done_k, 0)), 32'd5);
    check("post-reset done id", 32'(qget(ev_done_id, 0)), 32'd50);
  endtask

  task automatic drive_random(input int n, input int wr_pct, inout int dones);
    for (int i = 0; i < n; i++) begin
      // An offer that was not taken stays put with the same payload.
      if (!req0_valid || g0) begin
        req0_valid     = ($urandom_range(99) < 45);
        req0_base_addr = AW'($urandom);
        req0_poly_id   = IW'($urandom);
      end
      if (!req1_valid || g1) begin
        req1_valid     = ($urandom_range(99) < 45);
        req1_base_addr = AW'($urandom);
        req1_poly_id   = IW'($urandom);
      end
      encode_wr_en = ($urandom_range(99) < wr_pct);
      cyc();
      if (snap_dv) dones++;
    end
  endtask

  task automatic test_random();
    int dones;
    dones = 0;
    drive_random(800, 70, dones);
    drive_random(700, 5, dones);
    do_reset();
    drive_random(800, 40, dones);
    drive_random(700, 95, dones);
    req0_valid = 0; req1_valid = 0; encode_wr_en = 0;
    check("random completions seen", 32'(dones > 50), 32'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0; cnum = 0;
    rst_n = 1'b1;
    #1;
    do_reset();
    test_contention();
    test_single();
    test_timeout();
    test_reset_mid_job();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
